// File: rtl/keyboard_cmd_pkg.sv
// Shared PS/2 keyboard command encodings and scancodes.
// Used by the receiver, the decoder and the downstream game controller.
package keyboard_cmd_pkg;

  localparam logic [1:0] CMD_UP    = 2'b00;
  localparam logic [1:0] CMD_LEFT  = 2'b01;
  localparam logic [1:0] CMD_RIGHT = 2'b10;
  localparam logic [1:0] CMD_ENTER = 2'b11;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_ENTER = 8'h5A;

  typedef enum logic {
    RX_IDLE,
    RX_RECV
  } rx_state_t;

endpackage

// File: rtl/keyboard_cmd_ps2_rx.sv
// PS/2 frame receiver: sync, clock filter, 11-bit frame, timeout.
// Ports: clk, rst(n), ps2_clk, ps2_data -> data_byte, byte_valid, frame_err.
module ps2_rx
  import keyboard_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          clk_m, clk_s, clk_f;
  logic          dat_m, dat_s;
  logic [FW-1:0] flt_cnt;
  logic          flt_accept;
  logic          fall;

  rx_state_t     state, state_n;
  logic [3:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par;
  logic [TW-1:0] tmo;
  logic          timeout;

  // A level change is taken only after FILTER_LEN stable samples.
  assign flt_accept = (clk_s != clk_f)
                    && (flt_cnt == FW'(FILTER_LEN - 1));
  assign fall       = flt_accept && clk_f;
  assign timeout    = (tmo == TW'(TIMEOUT_CYCLES - 1)) && !fall;
  assign data_byte  = shift;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_m   <= 1'b1;
      clk_s   <= 1'b1;
      dat_m   <= 1'b1;
      dat_s   <= 1'b1;
      clk_f   <= 1'b1;
      flt_cnt <= '0;
    end else begin
      clk_m <= ps2_clk;
      clk_s <= clk_m;
      dat_m <= ps2_data;
      dat_s <= dat_m;
      if (clk_s == clk_f) begin
        flt_cnt <= '0;
      end else if (flt_accept) begin
        clk_f   <= clk_s;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_n    = state;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    unique case (state)
      RX_IDLE: begin
        if (fall && !dat_s) state_n = RX_RECV;
      end
      RX_RECV: begin
        if (fall && bit_cnt == 4'd9) begin
          state_n = RX_IDLE;
          // odd parity over data+parity, stop must be 1
          if ((^{shift, par}) && dat_s) byte_valid = 1'b1;
          else                          frame_err  = 1'b1;
        end else if (timeout) begin
          state_n   = RX_IDLE;
          frame_err = 1'b1;
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RX_IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      par     <= 1'b0;
      tmo     <= '0;
    end else begin
      state <= state_n;
      if (state == RX_RECV && state_n == RX_RECV) begin
        if (fall) begin
          tmo     <= '0;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt < 4'd8)       shift <= {dat_s, shift[7:1]};
          else if (bit_cnt == 4'd8) par   <= dat_s;
        end else begin
          tmo <= tmo + 1'b1;
        end
      end else begin
        bit_cnt <= '0;
        tmo     <= '0;
      end
    end
  end

endmodule

// File: rtl/keyboard_cmd.sv
// PS/2 keyboard to game command decoder (arrows + enter).
// Ports: clk, rst(n), ps2_clk, ps2_data -> keyboard_signal, key_valid, frame_err.
module keyboard_cmd
  import keyboard_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [1:0] keyboard_signal,
  output logic       key_valid,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;
  logic       ext, brk;
  logic       hit;
  logic [1:0] cmd;

  ps2_rx #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .FILTER_LEN     (FILTER_LEN)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .data_byte  (rx_byte),
    .byte_valid (rx_valid),
    .frame_err  (rx_err)
  );

  always_comb begin
    hit = 1'b0;
    cmd = CMD_UP;
    unique case (1'b1)
      (ext && rx_byte == SC_UP): begin
        hit = 1'b1;
        cmd = CMD_UP;
      end
      (ext && rx_byte == SC_LEFT): begin
        hit = 1'b1;
        cmd = CMD_LEFT;
      end
      (ext && rx_byte == SC_RIGHT): begin
        hit = 1'b1;
        cmd = CMD_RIGHT;
      end
      (rx_byte == SC_ENTER): begin
        hit = 1'b1;
        cmd = CMD_ENTER;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext             <= 1'b0;
      brk             <= 1'b0;
      keyboard_signal <= CMD_UP;
      key_valid       <= 1'b0;
      frame_err       <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      frame_err <= rx_err;
      if (rx_err) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (rx_valid) begin
        if (rx_byte == SC_EXT) begin
          ext <= 1'b1;
        end else if (rx_byte == SC_BRK) begin
          brk <= 1'b1;
        end else begin
          // any non-prefix byte ends the sequence; releases emit nothing
          ext <= 1'b0;
          brk <= 1'b0;
          if (!brk && hit) begin
            key_valid       <= 1'b1;
            keyboard_signal <= cmd;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_keyboard_cmd.sv
// Randomized + directed bench for keyboard_cmd.
// Reference model tracks the scancode sequence at protocol level.
module tb_keyboard_cmd;

  localparam int TMO  = 300;
  localparam int FL   = 4;
  localparam int HALF = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [1:0] keyboard_signal;
  logic       key_valid;
  logic       frame_err;

  keyboard_cmd #(
    .TIMEOUT_CYCLES (TMO),
    .FILTER_LEN     (FL)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ps2_clk         (ps2_clk),
    .ps2_data        (ps2_data),
    .keyboard_signal (keyboard_signal),
    .key_valid       (key_valid),
    .frame_err       (frame_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int stop_cyc = 0;
  int kv_cnt = 0;
  int fe_cnt = 0;
  int exp_kv = 0;
  int exp_fe = 0;
  logic prev_kv = 1'b0;

  bit m_ext = 0;
  bit m_rel = 0;
  logic [1:0] m_sig = 2'b00;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (key_valid) begin
      kv_cnt++;
      chk("kv_fe_excl", {31'd0, frame_err}, 0);
      chk("kv_width", {31'd0, prev_kv}, 0);
      chk("kv_lat",
          {31'd0, (cyc - stop_cyc) >= FL && (cyc - stop_cyc) <= FL + 4},
          1);
    end
    if (frame_err) fe_cnt++;
    prev_kv = key_valid;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Protocol-level model: prefixes E0 / F0 qualify the next byte.
  task automatic model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      exp_fe++;
      m_ext = 0;
      m_rel = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_rel = 1;
    end else begin
      if (!m_rel) begin
        if (b == 8'h5A) begin
          m_sig = 2'b11; exp_kv++;
        end else if (m_ext && b == 8'h75) begin
          m_sig = 2'b00; exp_kv++;
        end else if (m_ext && b == 8'h6B) begin
          m_sig = 2'b01; exp_kv++;
        end else if (m_ext && b == 8'h74) begin
          m_sig = 2'b10; exp_kv++;
        end
      end
      m_ext = 0;
      m_rel = 0;
    end
  endtask

  task automatic model_reset();
    m_ext = 0;
    m_rel = 0;
    m_sig = 2'b00;
  endtask

  task automatic send(input logic [7:0] b, input bit bad_par,
                      input int nbits, input bit glitch,
                      input bit rst_mid);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      wait_cyc(HALF);
      if (rst_mid && i == 4) begin
        rst = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(3);
        chk("rst_sig", {30'd0, keyboard_signal}, 0);
        chk("rst_kv", {31'd0, key_valid}, 0);
        chk("rst_fe", {31'd0, frame_err}, 0);
        model_reset();
        rst = 1'b1;
        wait_cyc(HALF);
        return;
      end
      ps2_clk = 1'b1;
      if (glitch && i == 3) begin
        wait_cyc(4);
        ps2_clk = 1'b0;
        wait_cyc(2);
        ps2_clk = 1'b1;
        wait_cyc(HALF - 6);
      end else begin
        wait_cyc(HALF);
      end
    end
    ps2_data = 1'b1;
  endtask

  task automatic frame(input logic [7:0] b, input bit bad,
                       input bit glitch);
    send(b, bad, 11, glitch, 1'b0);
    model_byte(b, !bad);
    wait_cyc(40);
    chk("kv_count", kv_cnt, exp_kv);
    chk("fe_count", fe_cnt, exp_fe);
    chk("signal", {30'd0, keyboard_signal}, {30'd0, m_sig});
  endtask

  logic [7:0] pool [6];

  initial begin
    pool[0] = 8'hE0; pool[1] = 8'hF0; pool[2] = 8'h75;
    pool[3] = 8'h6B; pool[4] = 8'h74; pool[5] = 8'h5A;
    rst = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(5);
    chk("reset_sig", {30'd0, keyboard_signal}, 0);
    chk("reset_kv", {31'd0, key_valid}, 0);
    chk("reset_fe", {31'd0, frame_err}, 0);
    rst = 1'b1;
    wait_cyc(5);

    frame(8'hE0, 0, 0); frame(8'h75, 0, 0);
    frame(8'hE0, 0, 0); frame(8'hF0, 0, 0); frame(8'h75, 0, 0);
    frame(8'h5A, 0, 0);
    frame(8'hE0, 0, 0); frame(8'h6B, 0, 0);
    frame(8'hE0, 0, 0); frame(8'h74, 0, 0);
    frame(8'h5A, 1, 0);

    frame(8'hE0, 0, 0);
    send(8'h5A, 0, 6, 0, 0);
    model_byte(8'h00, 0);
    wait_cyc(TMO + 60);
    chk("tmo_fe", fe_cnt, exp_fe);
    chk("tmo_kv", kv_cnt, exp_kv);
    frame(8'h75, 0, 0);
    frame(8'h5A, 0, 0);

    send(8'hE0, 0, 11, 0, 1'b1);
    wait_cyc(40);
    chk("rstmid_kv", kv_cnt, exp_kv);
    frame(8'h75, 0, 0);

    frame(8'hE0, 0, 1); frame(8'h6B, 0, 1);

    for (int n = 0; n < 45; n++) begin
      logic [7:0] b;
      int p;
      p = $urandom_range(0, 7);
      if (p < 6) b = pool[p];
      else       b = 8'($urandom_range(0, 255));
      frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
